// File: rtl/mac_sequencer_if.sv
// mac_sequencer_if: job, beat, counter and result signals
// between the issuer/datapath side and the sequencer.
interface mac_sequencer_if;
  logic       start;
  logic [3:0] len;
  logic       abort;
  logic       op_valid;
  logic       op_ready;
  logic [3:0] count_out;
  logic       count_enb;
  logic       count_reset;
  logic       mac_clr;
  logic       mac_en;
  logic       busy;
  logic       result_valid;
  logic       result_ready;

  modport master (
    output start, len, abort, op_valid,
    output count_out, result_ready,
    input  op_ready, count_enb, count_reset,
    input  mac_clr, mac_en, busy, result_valid
  );

  modport slave (
    input  start, len, abort, op_valid,
    input  count_out, result_ready,
    output op_ready, count_enb, count_reset,
    output mac_clr, mac_en, busy, result_valid
  );
endinterface

// File: rtl/mac_sequencer.sv
// mac_sequencer: sequences one MAC job -- clear, feed beats,
// wait out pipeline latency, hold result until consumed.
module mac_sequencer #(
  parameter int MAC_LAT = 2
) (
  input  logic           clk_out,
  input  logic           rst,
  mac_sequencer_if.slave bus
);
  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    RUN,
    DRAIN,
    DONE
  } state_t;

  localparam logic [2:0] DRAIN_INIT =
    (MAC_LAT > 0) ? 3'(MAC_LAT - 1) : 3'd0;

  state_t     state;
  logic [3:0] len_q;
  logic [2:0] drain_q;
  logic       op_ready_q;
  logic       mac_clr_q;
  logic       result_valid_q;
  logic       busy_q;

  logic fire;
  logic last;
  logic take;
  logic cancel;

  // op_ready_q is only ever high in RUN, so this is a RUN beat
  assign fire   = op_ready_q & bus.op_valid;
  // count_out still holds the pre-increment value here
  assign last   = fire & (bus.count_out == len_q);
  assign take   = result_valid_q & bus.result_ready;
  assign cancel = bus.abort & busy_q;

  assign bus.op_ready     = op_ready_q;
  assign bus.mac_clr      = mac_clr_q;
  assign bus.result_valid = result_valid_q;
  assign bus.busy         = busy_q;

  // abort suppresses the beat so enable and clear never collide
  assign bus.mac_en    = fire & ~bus.abort & ~rst;
  assign bus.count_enb = fire & ~bus.abort & ~rst;

  assign bus.count_reset =
    ~rst & (mac_clr_q | take | cancel);

  // State register with registered Moore outputs
  always_ff @(posedge clk_out) begin
    if (rst) begin
      state          <= IDLE;
      len_q          <= '0;
      drain_q        <= '0;
      op_ready_q     <= 1'b0;
      mac_clr_q      <= 1'b0;
      result_valid_q <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      mac_clr_q <= 1'b0;
      if (cancel) begin
        state          <= IDLE;
        op_ready_q     <= 1'b0;
        result_valid_q <= 1'b0;
        busy_q         <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (bus.start && !bus.abort) begin
              state     <= CLEAR;
              len_q     <= bus.len;
              mac_clr_q <= 1'b1;
              busy_q    <= 1'b1;
            end
          end
          CLEAR: begin
            state      <= RUN;
            op_ready_q <= 1'b1;
          end
          RUN: begin
            if (last) begin
              op_ready_q <= 1'b0;
              if (MAC_LAT == 0) begin
                state          <= DONE;
                result_valid_q <= 1'b1;
              end else begin
                state   <= DRAIN;
                drain_q <= DRAIN_INIT;
              end
            end
          end
          DRAIN: begin
            if (drain_q == 3'd0) begin
              state          <= DONE;
              result_valid_q <= 1'b1;
            end else begin
              drain_q <= drain_q - 3'd1;
            end
          end
          DONE: begin
            if (bus.result_ready) begin
              state          <= IDLE;
              result_valid_q <= 1'b0;
              busy_q         <= 1'b0;
            end
          end
          default: begin
            state          <= IDLE;
            op_ready_q     <= 1'b0;
            result_valid_q <= 1'b0;
            busy_q         <= 1'b0;
          end
        endcase
      end
    end
  end
endmodule
